universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 131 +++++++++++++
 tb/tb_universal_shift_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   WIDTH-bit universal shift register. It can hold, shift right, shift left or
//   parallel-load. A saturating counter records the number of shifts since the
//   last load. 'drained' goes high once WIDTH shifts have moved the loaded word
//   fully out of the register.
//
// Configuration:
//   USR_ROTATE_EN - when defined, adds input 'rot'. When rot=1, shifts become
//                   rotates: the serial inputs are ignored and cnt holds.
//
// Parameters:
//   WIDTH      register width, 2..32
//   RESET_VAL  register contents after reset
//   CW         shift-counter width; it must be able to hold the value WIDTH
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   mode      in   [1:0] 00 hold, 01 shift right, 10 shift left, 11 load
//   pin       in   [WIDTH-1:0] parallel load data
//   sin_msb   in   serial bit entering out[WIDTH-1] on shift right
//   sin_lsb   in   serial bit entering out[0] on shift left
//   rot       in   rotate instead of shift (only with USR_ROTATE_EN)
//   out       out  [WIDTH-1:0] register contents
//   sout_lsb  out  out[0], no register stage
//   sout_msb  out  out[WIDTH-1], no register stage
//   cnt       out  [CW-1:0] shifts since the last load, saturating at WIDTH
//   drained   out  high when cnt == WIDTH
// -----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int unsigned             WIDTH     = 4,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter int unsigned             CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_msb,
  input  logic             sin_lsb,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CW-1:0]    cnt,
  output logic             drained
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             rot_en;

`ifdef USR_ROTATE_EN
  assign rot_en = rot;
`else
  assign rot_en = 1'b0;
`endif

  // Saturating increment: once the word has drained, further shifts keep
  // moving data but the count stays at WIDTH.
  assign cnt_inc = (cnt_q < CNT_FULL) ? cnt_q + CW'(1) : cnt_q;

  // NOTE: every output of this block is given a default first. Then no path
  // leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    unique case (mode_e'(mode))
      MODE_HOLD: ;
      MODE_RIGHT: begin
        if (rot_en) begin
          out_d = {out_q[0], out_q[WIDTH-1:1]};
        end else begin
          out_d = {sin_msb, out_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
      end
      MODE_LEFT: begin
        if (rot_en) begin
          out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        end else begin
          out_d = {out_q[WIDTH-2:0], sin_lsb};
          cnt_d = cnt_inc;
        end
      end
      MODE_LOAD: begin
        out_d = pin;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Reset forces the drained state: the register is treated as empty, so the
  // counter starts saturated.
  // NOTE: state registers use non-blocking assignments. All flops then sample
  // their pre-edge values, and simulation matches the synthesized hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RESET_VAL;
      cnt_q <= CNT_FULL;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  // The serial outputs come straight from the register. A downstream stage
  // clocked on the same edge therefore captures the bit as it leaves.
  assign out      = out_q;
  assign sout_lsb = out_q[0];
  assign sout_msb = out_q[WIDTH-1];
  assign cnt      = cnt_q;
  assign drained  = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Self-checking bench for universal_shift_reg with WIDTH=4 and RESET_VAL=0.
// The stimulus process drives directed vectors. After each vector it pushes
// the hand-computed register state into a scoreboard queue. An independent
// monitor process pops each entry and compares it with the DUT outputs 1 ns
// after the update.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  pin = '0;
  logic          sin_msb = 1'b0;
  logic          sin_lsb = 1'b0;
  logic          rot = 1'b0;
  logic [W-1:0]  out;
  logic          sout_lsb, sout_msb;
  logic [CW-1:0] cnt;
  logic          drained;

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .pin      (pin),
    .sin_msb  (sin_msb),
    .sin_lsb  (sin_lsb),
`ifdef USR_ROTATE_EN
    .rot      (rot),
`endif
    .out      (out),
    .sout_lsb (sout_lsb),
    .sout_msb (sout_msb),
    .cnt      (cnt),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [W-1:0]  out;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected serial outputs and drained are derived from the expected word and
  // count.
  initial begin
    exp_t e;
    logic [W-1:0] o;
    logic [CW-1:0] c;
    logic          d, sl, sm;
    forever begin
      wait (sb.size() > 0);
      #1;
      e  = sb.pop_front();
      o  = e.out;
      c  = e.cnt;
      d  = (c == CW'(W));
      sl = o[0];
      sm = o[W-1];
      checks++;
      if (out !== o || cnt !== c || drained !== d ||
          sout_lsb !== sl || sout_msb !== sm) begin
        errors++;
        $display("FAIL %s: got out=%b cnt=%0d drained=%b sl=%b sm=%b, want out=%b cnt=%0d drained=%b sl=%b sm=%b",
                 e.name, out, cnt, drained, sout_lsb, sout_msb, o, c, d, sl, sm);
      end
    end
  end

  task automatic push(input string nm, input logic [W-1:0] o, input logic [CW-1:0] c);
    exp_t e;
    e.name = nm;
    e.out  = o;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Drive one vector before the edge and queue the state expected after it.
  task automatic step(input string nm, input logic [1:0] m, input logic [W-1:0] p,
                      input logic smsb, input logic slsb, input logic rt,
                      input logic [W-1:0] eo, input logic [CW-1:0] ec);
    @(negedge clk);
    mode = m; pin = p; sin_msb = smsb; sin_lsb = slsb; rot = rt;
    @(posedge clk);
    push(nm, eo, ec);
  endtask

  initial begin
    // Asynchronous reset between edges, checked before any clock edge.
    #2 rst = 1'b1;
    #1 push("reset_async", 4'b0000, 3'd4);
    @(negedge clk);
    rst = 1'b0;

    // Parallel load.
    step("load_1011", 2'b11, 4'b1011, 0, 0, 0, 4'b1011, 3'd0);

    // Shift right into saturation; shifting continues after drained.
    step("sr1", 2'b01, 4'b0000, 0, 0, 0, 4'b0101, 3'd1);
    step("sr2", 2'b01, 4'b0000, 0, 0, 0, 4'b0010, 3'd2);
    step("sr3", 2'b01, 4'b0000, 0, 0, 0, 4'b0001, 3'd3);
    step("sr4", 2'b01, 4'b0000, 0, 0, 0, 4'b0000, 3'd4);
    step("sr5", 2'b01, 4'b0000, 0, 0, 0, 4'b0000, 3'd4);
    step("sr6_sin1_sat", 2'b01, 4'b0000, 1, 0, 0, 4'b1000, 3'd4);

    // A load after saturation clears cnt and drained.
    step("load_after_sat", 2'b11, 4'b0001, 0, 0, 0, 4'b0001, 3'd0);

    // Shift left, then hold.
    step("sl1", 2'b10, 4'b0000, 0, 1, 0, 4'b0011, 3'd1);
    step("sl2", 2'b10, 4'b0000, 0, 1, 0, 4'b0111, 3'd2);
    step("hold1", 2'b00, 4'b1111, 1, 0, 0, 4'b0111, 3'd2);
    step("hold2", 2'b00, 4'b0000, 1, 1, 0, 4'b0111, 3'd2);

    // Back-to-back mode changes with no dead cycle.
    step("b2b_sr", 2'b01, 4'b0000, 1, 0, 0, 4'b1011, 3'd3);
    step("b2b_sl", 2'b10, 4'b0000, 0, 0, 0, 4'b0110, 3'd4);
    step("b2b_ld", 2'b11, 4'b1100, 0, 0, 0, 4'b1100, 3'd0);

    // Reset mid-sequence aborts the shifts; inputs are ignored while reset is high.
    step("mid_sr1", 2'b01, 4'b0000, 0, 0, 0, 4'b0110, 3'd1);
    step("mid_sr2", 2'b01, 4'b0000, 0, 0, 0, 4'b0011, 3'd2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 push("mid_reset_async", 4'b0000, 3'd4);
    step("reset_ignores_load", 2'b11, 4'b1111, 0, 0, 0, 4'b0000, 3'd4);
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b11; pin = 4'b0110;
    @(posedge clk);
    push("first_after_reset", 4'b0110, 3'd0);

`ifdef USR_ROTATE_EN
    step("rot_load", 2'b11, 4'b1001, 0, 0, 0, 4'b1001, 3'd0);
    step("rot_r1", 2'b01, 4'b0000, 0, 0, 1, 4'b1100, 3'd0);
    step("rot_r2", 2'b01, 4'b0000, 0, 0, 1, 4'b0110, 3'd0);
    step("rot_r3", 2'b01, 4'b0000, 0, 0, 1, 4'b0011, 3'd0);
    step("rot_r4", 2'b01, 4'b0000, 0, 0, 1, 4'b1001, 3'd0);
    step("rot_l1", 2'b10, 4'b0000, 0, 0, 1, 4'b0011, 3'd0);
    step("rot_off_sr", 2'b01, 4'b0000, 1, 0, 0, 4'b1001, 3'd1);
`endif

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
